reqwalker_master: RTL

Wishbone pipelined bus initiator that drives the LED-walker responder. On a trigger pulse it opens a bus cycle, issues one write to start a walk, and, optionally, polls the responder's state register by reads until the walk finishes. It sits between a debounced button/trigger source and the walker's slave port. It reports busy, completion count and a sticky timeout error.

---
 rtl/reqwalker_master.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/reqwalker_master.sv
`default_nettype none
// ============================================================================
// Module   : reqwalker_master
// Purpose  : Wishbone pipelined initiator that starts an LED walk with one
//            write and, when REQWALKER_MASTER_POLL_EN is defined, polls the
//            walker state by reads until it returns to state 0.
// Revision : 1.0 - initial release
// ============================================================================
module reqwalker_master #(
    parameter int TIMEOUT = 31,
    parameter int CW      = 8
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_trigger,
    output logic          o_cyc,
    output logic          o_stb,
    output logic          o_we,
    output logic          o_addr,
    output logic [31:0]   o_data,
    input  logic          i_stall,
    input  logic          i_ack,
    input  logic [31:0]   i_data,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [CW-1:0] o_count
);

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_WAIT = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          cyc_q, cyc_d;
    logic          stb_q, stb_d;
    logic          we_q, we_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [CW-1:0] count_q, count_d;
    logic          tmo_hit;
    logic          finish;
    logic          unused_data;

    assign tmo_hit = (tmo_q == TMO_LAST);

`ifdef REQWALKER_MASTER_POLL_EN
    assign unused_data = ^i_data[31:4];
`else
    assign unused_data = ^i_data;
`endif

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        finish  = 1'b0;

        case (state_q)
            IDLE: begin
                // A trigger landing on the done pulse belongs to the finished sequence.
                if (i_trigger && !done_q) begin
                    state_d = WR_REQ;
                    err_d   = 1'b0;
                end
            end
            WR_REQ: begin
                if (!i_stall) begin
                    state_d = WR_WAIT;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            WR_WAIT: begin
                if (i_ack) begin
`ifdef REQWALKER_MASTER_POLL_EN
                    state_d = RD_REQ;
`else
                    state_d = IDLE;
                    finish  = 1'b1;
`endif
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
`ifdef REQWALKER_MASTER_POLL_EN
            RD_REQ: begin
                if (!i_stall) begin
                    state_d = RD_WAIT;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            RD_WAIT: begin
                if (i_ack) begin
                    if (i_data[3:0] == 4'h0) begin
                        state_d = IDLE;
                        finish  = 1'b1;
                    end else begin
                        state_d = RD_REQ;
                    end
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Budget restarts on every state change and never runs while idle.
        if ((state_d != state_q) || (state_q == IDLE)) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        cyc_d   = (state_d != IDLE);
        stb_d   = (state_d == WR_REQ) || (state_d == RD_REQ);
        we_d    = (state_d == WR_REQ);
        done_d  = finish;
        count_d = count_q + {{(CW-1){1'b0}}, finish};
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    assign o_cyc   = cyc_q;
    assign o_stb   = stb_q;
    assign o_we    = we_q;
    assign o_addr  = 1'b0;
    assign o_data  = 32'h0;
    assign o_busy  = cyc_q;
    assign o_done  = done_q;
    assign o_err   = err_q;
    assign o_count = count_q;

endmodule
`default_nettype wire
